// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (fetch/data) arbiter onto a single acked shared bus
module mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_ce_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_data_o,
    output logic        if_stallreq_o,
    input  logic        mem_ce_i,
    input  logic        mem_we_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] mem_data_o,
    output logic        mem_stallreq_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_data_o,
    input  logic [31:0] bus_data_i,
    input  logic        bus_ack_i,
    output logic        bus_err_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_IF_BUSY,
        ST_MEM_BUSY,
        ST_IF_DONE,
        ST_MEM_DONE
    } state_e;

    // Abort fires on the BUSY cycle whose increment would make the count equal the limit.
    localparam logic [8:0] TMO_LIMIT = 9'(TIMEOUT_CYCLES);
    localparam bit         TMO_EN    = (TIMEOUT_CYCLES != 0);

    state_e      state_q, state_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [3:0]  bus_sel_q, bus_sel_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_data_q, bus_data_d;
    logic        bus_err_q, bus_err_d;
    logic [31:0] if_data_q, if_data_d;
    logic [31:0] mem_data_q, mem_data_d;
    logic [7:0]  tmo_cnt_q, tmo_cnt_d;
    logic        flush_q, flush_d;

    logic        is_if_busy;
    logic        req_ce;
    logic        flushed;
    logic        timeout_hit;

    // Next-state, bus command latching, completion/abort handling.
    always_comb begin
        state_d    = state_q;
        bus_req_d  = bus_req_q;
        bus_we_d   = bus_we_q;
        bus_sel_d  = bus_sel_q;
        bus_addr_d = bus_addr_q;
        bus_data_d = bus_data_q;
        bus_err_d  = 1'b0;
        if_data_d  = if_data_q;
        mem_data_d = mem_data_q;
        tmo_cnt_d  = tmo_cnt_q;
        flush_d    = flush_q;

        is_if_busy  = (state_q == ST_IF_BUSY);
        req_ce      = is_if_busy ? if_ce_i : mem_ce_i;
        // Once the owner lets go of its request the result is no longer wanted,
        // even if it reasserts before the bus finishes.
        flushed     = flush_q | ~req_ce;
        timeout_hit = TMO_EN && (({1'b0, tmo_cnt_q} + 9'd1) == TMO_LIMIT);

        case (state_q)
            ST_IDLE: begin
                if (mem_ce_i) begin
                    state_d    = ST_MEM_BUSY;
                    bus_req_d  = 1'b1;
                    bus_we_d   = mem_we_i;
                    bus_sel_d  = mem_sel_i;
                    bus_addr_d = mem_addr_i;
                    bus_data_d = mem_data_i;
                    tmo_cnt_d  = 8'd0;
                    flush_d    = 1'b0;
                end else if (if_ce_i) begin
                    state_d    = ST_IF_BUSY;
                    bus_req_d  = 1'b1;
                    bus_we_d   = 1'b0;
                    bus_sel_d  = 4'b1111;
                    bus_addr_d = if_addr_i;
                    bus_data_d = 32'd0;
                    tmo_cnt_d  = 8'd0;
                    flush_d    = 1'b0;
                end
            end
            ST_IF_BUSY, ST_MEM_BUSY: begin
                flush_d = flushed;
                if (bus_ack_i) begin
                    bus_req_d = 1'b0;
                    tmo_cnt_d = 8'd0;
                    if (flushed) begin
                        state_d = ST_IDLE;
                    end else if (is_if_busy) begin
                        if_data_d = bus_data_i;
                        state_d   = ST_IF_DONE;
                    end else begin
                        if (!bus_we_q) begin
                            mem_data_d = bus_data_i;
                        end
                        state_d = ST_MEM_DONE;
                    end
                end else if (timeout_hit) begin
                    bus_req_d = 1'b0;
                    bus_err_d = 1'b1;
                    tmo_cnt_d = 8'd0;
                    if (flushed) begin
                        state_d = ST_IDLE;
                    end else if (is_if_busy) begin
                        if_data_d = 32'd0;
                        state_d   = ST_IF_DONE;
                    end else begin
                        if (!bus_we_q) begin
                            mem_data_d = 32'd0;
                        end
                        state_d = ST_MEM_DONE;
                    end
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
            end
            ST_IF_DONE, ST_MEM_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bus_req_q  <= 1'b0;
            bus_we_q   <= 1'b0;
            bus_sel_q  <= 4'd0;
            bus_addr_q <= 32'd0;
            bus_data_q <= 32'd0;
            bus_err_q  <= 1'b0;
            if_data_q  <= 32'd0;
            mem_data_q <= 32'd0;
            tmo_cnt_q  <= 8'd0;
            flush_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            bus_req_q  <= bus_req_d;
            bus_we_q   <= bus_we_d;
            bus_sel_q  <= bus_sel_d;
            bus_addr_q <= bus_addr_d;
            bus_data_q <= bus_data_d;
            bus_err_q  <= bus_err_d;
            if_data_q  <= if_data_d;
            mem_data_q <= mem_data_d;
            tmo_cnt_q  <= tmo_cnt_d;
            flush_q    <= flush_d;
        end
    end

    assign if_stallreq_o  = ~rst & if_ce_i  & (state_q != ST_IF_DONE);
    assign mem_stallreq_o = ~rst & mem_ce_i & (state_q != ST_MEM_DONE);

    assign if_data_o  = if_data_q;
    assign mem_data_o = mem_data_q;
    assign bus_req_o  = bus_req_q;
    assign bus_we_o   = bus_we_q;
    assign bus_sel_o  = bus_sel_q;
    assign bus_addr_o = bus_addr_q;
    assign bus_data_o = bus_data_q;
    assign bus_err_o  = bus_err_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 255, bus cycles to wait for bus_ack_i before abort (0 = never abort).
REQ-002 clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 if_ce_i  in  1  instruction-fetch read request.
REQ-005 if_addr_i  in  32  fetch address.
REQ-006 if_data_o  out  32  fetched instruction, registered.
REQ-007 if_stallreq_o  out  1  fetch not yet complete; pipeline must hold the fetch stage.
REQ-008 mem_ce_i  in  1  data-access request.
REQ-009 mem_we_i  in  1  1 = store, 0 = load.
REQ-010 mem_sel_i  in  4  byte enables.
REQ-011 mem_addr_i  in  32  data address.
REQ-012 mem_data_i  in  32  store data.
REQ-013 mem_data_o  out  32  load data, registered.
REQ-014 mem_stallreq_o  out  1  data access not yet complete.
REQ-015 bus_req_o  out  1  shared-bus cycle active, registered.
REQ-016 bus_we_o, bus_sel_o (4), bus_addr_o (32), bus_data_o (32)  out  registered shared-bus command.
REQ-017 bus_data_i  in  32  bus read data; bus_ack_i  in  1  one-cycle completion strobe.
REQ-018 bus_err_o  out  1  one-cycle pulse on timeout abort.

Function
REQ-019 States: IDLE, IF_BUSY, MEM_BUSY, IF_DONE, MEM_DONE.
REQ-020 IDLE: mem_ce_i=1 -> MEM_BUSY; else if_ce_i=1 -> IF_BUSY; else stay. Data port has fixed priority on simultaneous requests.
REQ-021 On grant edge: bus_req_o<=1 and latch requester's we/sel/addr/data into bus_* (fetch: we=0, sel=4'b1111, data=0); bus_* stable until ack.
REQ-022 In *_BUSY with bus_ack_i=1: bus_req_o<=0, bus_data_i captured into if_data_o or mem_data_o (stores capture nothing), state -> matching *_DONE.
REQ-023 *_DONE lasts exactly one cycle, then -> IDLE; no new grant from *_DONE.
REQ-024 if_stallreq_o = if_ce_i AND NOT(state==IF_DONE); mem_stallreq_o = mem_ce_i AND NOT(state==MEM_DONE); combinational from state and request.
REQ-025 Minimum latency: request seen cycle 0, ack cycle 1, stallreq low and data valid cycle 2.
REQ-026 Timeout: 8-bit counter cleared on grant, increments each BUSY cycle without ack; when TIMEOUT_CYCLES!=0 and count reaches TIMEOUT_CYCLES, abort: bus_req_o<=0, captured data<=0, bus_err_o pulses one cycle, -> *_DONE.
REQ-027 Ack and timeout in same cycle: ack wins, no bus_err_o.
REQ-028 Requester dropping ce during BUSY (flush): bus cycle still completes; data discarded (outputs unchanged); -> IDLE directly, skipping DONE.
REQ-029 bus_ack_i in IDLE or DONE ignored.
REQ-030 if_data_o/mem_data_o hold last captured value until next capture.
REQ-031 A request still asserted in IDLE after its DONE is re-serviced as a new transaction (requester deasserts or changes it when its stage advances).

Reset
REQ-032 rst=1 at edge: state<=IDLE, bus_req_o/bus_we_o/bus_err_o<=0, bus_sel_o<=0, bus_addr_o/bus_data_o/if_data_o/mem_data_o<=0, counter<=0.
REQ-033 Reset mid-transaction aborts without bus_err_o; pending ack after reset ignored.
REQ-034 While rst=1 both stallreq outputs are 0.

Verification
REQ-035 Fetch only: if_ce_i=1, addr 0x100, ack cycle 1 with data 0x3C010001 -> bus_addr_o=0x100, bus_we_o=0, if_stallreq_o=1 cycles 0-1, 0 cycle 2 with if_data_o=0x3C010001.
REQ-036 Simultaneous: if_ce_i=mem_ce_i=1 (load 0x200) -> MEM granted first; IF granted in cycle after MEM_DONE; if_stallreq_o high throughout MEM transaction.
REQ-037 Store: mem_we_i=1, sel 4'b0011, addr 0x80, data 0xDEADBEEF, ack after 3 cycles -> bus fields exact and stable all 3 cycles, mem_data_o unchanged.
REQ-038 Timeout: TIMEOUT_CYCLES=4, no ack -> bus_req_o falls after 4 BUSY cycles, bus_err_o one pulse, mem_data_o=0, mem_stallreq_o low in DONE.
REQ-039 Flush: if_ce_i drops during IF_BUSY, ack later with 0x12345678 -> if_data_o unchanged, state returns IDLE, no DONE cycle.
REQ-040 Reset mid-MEM_BUSY: rst one cycle -> all outputs at reset values next cycle; later stray bus_ack_i ignored.
